// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one RAM controller between the
// instruction cache (port 0) and the data cache (port 1).
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data_in,
    input  logic              p0_MemRead,
    input  logic              p0_MemWrite,
    output logic [DATA_W-1:0] p0_data_out,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data_in,
    input  logic              p1_MemRead,
    input  logic              p1_MemWrite,
    output logic [DATA_W-1:0] p1_data_out,
    output logic              p1_ready,
    output logic [ADDR_W-1:0] arb2mem_addr,
    output logic [DATA_W-1:0] arb2mem_data,
    output logic              arb2mem_MemRead,
    output logic              arb2mem_MemWrite,
    input  logic [DATA_W-1:0] mem2arb_data_in,
    input  logic              mem2arb_ready,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t            state;
    logic              last;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              p0_req;
    logic              p1_req;
    logic              pick_p1;

    always_comb begin
        p0_req  = p0_MemRead | p0_MemWrite;
        p1_req  = p1_MemRead | p1_MemWrite;
        // On a tie the port that was not served last wins.
        pick_p1 = p1_req & (~p0_req | ~last);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state            <= IDLE;
            last             <= 1'b1;
            lat_addr         <= '0;
            lat_data         <= '0;
            grant_id         <= 1'b0;
            arb2mem_MemRead  <= 1'b0;
            arb2mem_MemWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_p1) begin
                        state            <= GRANT1;
                        lat_addr         <= p1_addr;
                        lat_data         <= p1_data_in;
                        last             <= 1'b1;
                        grant_id         <= 1'b1;
                        arb2mem_MemRead  <= ~p1_MemWrite;
                        arb2mem_MemWrite <= p1_MemWrite;
                    end else if (p0_req) begin
                        state            <= GRANT0;
                        lat_addr         <= p0_addr;
                        lat_data         <= p0_data_in;
                        last             <= 1'b0;
                        grant_id         <= 1'b0;
                        arb2mem_MemRead  <= ~p0_MemWrite;
                        arb2mem_MemWrite <= p0_MemWrite;
                    end
                end
                GRANT0: begin
                    // Completion or a requester abandoning the access both end the grant.
                    if (mem2arb_ready || !p0_req) begin
                        state            <= IDLE;
                        arb2mem_MemRead  <= 1'b0;
                        arb2mem_MemWrite <= 1'b0;
                    end
                end
                GRANT1: begin
                    if (mem2arb_ready || !p1_req) begin
                        state            <= IDLE;
                        arb2mem_MemRead  <= 1'b0;
                        arb2mem_MemWrite <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    arb2mem_MemRead  <= 1'b0;
                    arb2mem_MemWrite <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        arb2mem_addr = lat_addr;
        arb2mem_data = lat_data;
        p0_ready     = (state == GRANT0) && mem2arb_ready;
        p1_ready     = (state == GRANT1) && mem2arb_ready;
        p0_data_out  = (state == GRANT0) ? mem2arb_data_in : '0;
        p1_data_out  = (state == GRANT1) ? mem2arb_data_in : '0;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the byte-address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the word width of all data ports.
REQ-003 iCLK  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 iRST_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 p0_addr / p1_addr  input  ADDR_W  SHALL carry the requester address; port 0 is the instruction cache and port 1 is the data cache.
REQ-006 p0_data_in / p1_data_in  input  DATA_W  SHALL carry the requester write data.
REQ-007 p0_MemRead, p0_MemWrite / p1_MemRead, p1_MemWrite  input  1 each  SHALL be the level-held request strobes.
REQ-008 p0_data_out / p1_data_out  output  DATA_W  SHALL carry the read data returned to the requester.
REQ-009 p0_ready / p1_ready  output  1 each  SHALL be the per-port completion pulse.
REQ-010 arb2mem_addr  output  ADDR_W  SHALL carry the address presented to the RAM controller.
REQ-011 arb2mem_data  output  DATA_W  SHALL carry the write data presented to the RAM controller.
REQ-012 arb2mem_MemRead / arb2mem_MemWrite  output  1 each  SHALL be the RAM request strobes.
REQ-013 mem2arb_data_in  input  DATA_W  SHALL carry the RAM read data.
REQ-014 mem2arb_ready  input  1  SHALL be the RAM completion flag.
REQ-015 grant_id  output  1  SHALL indicate the currently or last granted port; it is a debug output.

Function
REQ-016 A port is requesting when its MemRead or MemWrite is 1; if both are 1, the request SHALL be treated as a write.
REQ-017 The FSM SHALL have exactly three states: IDLE, GRANT0 and GRANT1.
REQ-018 In IDLE with exactly one port requesting, the FSM SHALL go to GRANTx of that port at the next edge.
REQ-019 In IDLE with both ports requesting, the FSM SHALL grant the port not equal to register last (round-robin); last resets to 1, so port 0 wins the first tie.
REQ-020 On entry to GRANTx, the arbiter SHALL register the granted port's addr, data_in and rw into the latch, SHALL set last to x, and SHALL set grant_id to x.
REQ-021 arb2mem_addr and arb2mem_data SHALL be driven from the latch at all times.
REQ-022 arb2mem_MemRead SHALL be 1 only in a GRANT state with latched rw=0; arb2mem_MemWrite SHALL be 1 only in a GRANT state with latched rw=1.
REQ-023 In GRANTx with mem2arb_ready=1, px_ready SHALL be 1 combinationally in that cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-024 px_ready SHALL be 0 in every other cycle, and the non-granted port's ready SHALL always be 0.
REQ-025 px_data_out SHALL equal mem2arb_data_in while in GRANTx, and SHALL be 0 otherwise.
REQ-026 Latency: for an uncontended request, strobes rise 1 cycle after the request; mem2arb_ready in cycle k gives px_ready in cycle k; the FSM spends at least 1 IDLE cycle between grants.
REQ-027 A request arriving while the other port is granted SHALL wait, held by the requester, and SHALL be granted from the next IDLE cycle.
REQ-028 If the granted port drops both strobes before mem2arb_ready (protocol violation), the FSM SHALL return to IDLE at the next edge with no ready pulse.
REQ-029 A change to the granted port's addr or data while in GRANT SHALL NOT alter the arb2mem outputs.
REQ-030 mem2arb_ready=1 while in IDLE SHALL be ignored.
REQ-031 There SHALL be no timeout; a GRANT state holds indefinitely until mem2arb_ready or the drop condition of REQ-028.

Reset
REQ-032 When iRST_n=0, the arbiter SHALL immediately enter IDLE and clear state, last=1, latch=0, grant_id=0, all strobes=0, all ready=0 and all data_out=0; this applies mid-transaction.
REQ-033 After iRST_n rises, the first request SHALL be evaluated in the first IDLE cycle.

Verification
REQ-034 Port-0 read of addr 0x40 with RAM returning 0xDEADBEEF after 3 cycles -> arb2mem_MemRead=1 with addr 0x40 for 3 cycles; p0_ready pulses once with p0_data_out=0xDEADBEEF.
REQ-035 Both ports request in the same cycle after reset -> port 0 is granted first and port 1 next; repeating both requests -> grant order 0,1,0,1.
REQ-036 Port-1 write of 0x1234 to 0x80 while port 0 is granted -> port-1 strobes appear only after p0_ready plus one IDLE cycle; arb2mem_MemWrite=1 with data 0x1234.
REQ-037 Port 0 changes addr from 0x40 to 0x44 mid-grant -> arb2mem_addr stays 0x40.
REQ-038 iRST_n pulsed low during GRANT1 -> strobes=0 and ready=0 asynchronously; the next tie is granted to port 0.
REQ-039 Port 1 asserts both MemRead and MemWrite -> a write is issued (arb2mem_MemWrite=1, arb2mem_MemRead=0).
